sort_stream_sequencer: RTL and testbench
========================================

Name: sort_stream_sequencer

Overview:
Frame sequencer for the serial sorting array.
- Accepts a valid/ready stream of unsorted elements and loads them into the sorter in frames of exactly SIZE elements.
- After a settle interval, drains the sorted elements into a registered valid/ready output stream.
- Clears the sorter between frames.
- Sits between the upstream data source and the sorter's enable/write/unsorted_data/sorted_data interface, driving both sides of it.

Parameters:
DATA_WIDTH, 8, element width; must match the sorter.
SIZE, 3, elements per frame; must match the sorter depth; SIZE >= 1.
SETTLE_CYCLES, 1, idle cycles between the last insert and the first pop; 0 allowed (SETTLE state skipped).

Ports:
clk  in  1  clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
in_data  in  DATA_WIDTH  unsorted element.
in_valid  in  1  in_data valid.
in_ready  out  1  sequencer accepts in_data this cycle.
out_data  out  DATA_WIDTH  sorted element, registered.
out_valid  out  1  out_data valid.
out_last  out  1  marks the final element of a frame; qualified by out_valid.
out_ready  in  1  downstream accepts out_data.
sort_enable  out  1  to sorter enable.
sort_write  out  1  to sorter write: 1 = insert, 0 = pop.
sort_unsorted_data  out  DATA_WIDTH  to sorter unsorted_data.
sort_sorted_data  in  DATA_WIDTH  from sorter sorted_data; the current smallest remaining element.
sort_clear  out  1  to sorter reset.
busy  out  1  high whenever state != LOAD or cnt != 0.

Clocking and reset: one clock, clk. reset is synchronous and active-high.

Behaviour:
- Sorter contract:
  - Enabled write cycle inserts sort_unsorted_data.
  - Enabled non-write cycle pops the head.
  - sort_sorted_data shows the ascending-order head, valid SETTLE_CYCLES cycles after the final insert.
- States: LOAD, SETTLE, DRAIN, CLEAR. Counter cnt is $clog2(SIZE+1) bits.
- Reset state:
  - state = LOAD, cnt = 0, out_valid = 0, out_last = 0, out_data = 0.
  - sort_clear = 1 during reset (combinational OR of reset and state==CLEAR).
- LOAD:
  - in_ready = 1, sort_write = 1, sort_enable = in_valid, sort_unsorted_data = in_data (combinational).
  - Each handshake increments cnt.
  - When cnt reaches SIZE-1 with a handshake: go to SETTLE (or DRAIN if SETTLE_CYCLES = 0) and clear cnt.
- SETTLE:
  - in_ready = 0, sort_enable = 0.
  - Count SETTLE_CYCLES cycles, then go to DRAIN with cnt = 0.
- DRAIN:
  - pop = !out_valid || out_ready. sort_enable = pop, sort_write = 0.
  - On pop: out_data <= sort_sorted_data, out_valid <= 1, out_last <= (cnt == SIZE-1), cnt++.
  - The pop with cnt == SIZE-1 moves to CLEAR.
  - If no pop: out_valid, out_data and out_last hold (no data loss, no duplicate pops).
- Output register, all states:
  - If out_valid && out_ready and no pop this cycle, out_valid <= 0 and out_last <= 0.
  - The output register is independent of state, so the final element may remain pending while the next frame loads.
- CLEAR:
  - sort_clear = 1, sort_enable = 0, in_ready = 0 for exactly one cycle.
  - Then go to LOAD with cnt = 0.
- sort_write is 1 only in LOAD; it is 0 in all other states, including SETTLE and CLEAR.
- Frame latency: SIZE accepted inputs + SETTLE_CYCLES, then the first pop. Peak throughput is one frame per 2*SIZE + SETTLE_CYCLES + 1 cycles.
- Reset mid-frame: the partial frame is discarded, the pending output is dropped (out_valid = 0), and the sorter is cleared.
- No partial frames: LOAD waits indefinitely for SIZE elements.
- SIZE = 1: a single insert goes straight to SETTLE/DRAIN, and out_last = 1 on the only element.

Decomposition:
- Package sort_pkg holds the enum typedef sort_seq_state_t {LOAD, SETTLE, DRAIN, CLEAR} and the counter width function/constant shared with future sort blocks.
- Single module; no sub-module needed. The output register is inline.

Test Plan:
Bench uses DATA_WIDTH=8, SIZE=3, SETTLE_CYCLES=1, driving the real sorter or a behavioural model.
1. Inputs 5,2,9 back-to-back, out_ready=1 → sort_enable/sort_write high 3 cycles, 1 settle cycle, out stream 2,5,9 on consecutive cycles, out_last only on 9, sort_clear pulses one cycle after the third pop.
2. Same frame with out_ready=0 for 4 cycles after the first output → out_data holds 2 with out_valid=1, sort_enable=0 during the stall; the stream resumes 5,9 without loss or duplication.
3. in_valid toggling 1,0,1,0,1 with data 4,x,1,x,3 → exactly 3 inserts, outputs 1,3,4.
4. Duplicates 7,7,0 → outputs 0,7,7; out_last on the second 7.
5. Reset asserted for 1 cycle after the first output of a frame → out_valid=0 and sort_clear=1 that cycle; the next frame 1,3,2 yields 1,2,3.
6. Two frames back-to-back with out_ready=0 while the last element (9) is pending → in_ready=1 in LOAD of frame 2 while out_valid holds 9; DRAIN of frame 2 does not pop until 9 is accepted.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and sizing helpers for the sort block family.
package sort_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    DRAIN  = 2'd2,
    CLEAR  = 2'd3
  } sort_seq_state_t;

  // Width of a counter able to hold 0..n, never narrower than one bit.
  function automatic int sort_cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sort_stream_sequencer.sv
// Frame sequencer for the serial sorting array: loads SIZE elements,
// waits for the sorter to settle, drains them through a registered
// valid/ready output, then clears the sorter for the next frame.
module sort_stream_sequencer
  import sort_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int SIZE          = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  sort_enable,
  output logic                  sort_write,
  output logic [DATA_WIDTH-1:0] sort_unsorted_data,
  input  logic [DATA_WIDTH-1:0] sort_sorted_data,
  output logic                  sort_clear,
  output logic                  busy
);

  localparam int CNT_W = sort_cnt_width(SIZE);
  localparam int SET_W = sort_cnt_width(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SIZE - 1);
  localparam sort_seq_state_t AFTER_LOAD = (SETTLE_CYCLES == 0) ? DRAIN : SETTLE;

  sort_seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SET_W-1:0]       settle_q, settle_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic                   pop;

  // State, counters and output register; reset drops any pending output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      settle_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      settle_q    <= settle_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Next state, counters and output register contents.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    settle_d    = settle_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    case (state_q)
      LOAD: begin
        if (in_valid) begin
          if (cnt_q == LAST_IDX) begin
            state_d  = AFTER_LOAD;
            cnt_d    = '0;
            settle_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      SETTLE: begin
        if (int'(settle_q) == SETTLE_CYCLES - 1) begin
          state_d  = DRAIN;
          settle_d = '0;
          cnt_d    = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      DRAIN: begin
        if (pop) begin
          if (cnt_q == LAST_IDX) begin
            state_d = CLEAR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      CLEAR: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase

    // The output register runs independently of state so a pending last
    // element can wait downstream while the next frame loads.
    if (pop) begin
      out_data_d  = sort_sorted_data;
      out_valid_d = 1'b1;
      out_last_d  = (cnt_q == LAST_IDX);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // Sorter and stream handshake controls decoded from state.
  always_comb begin
    in_ready           = 1'b0;
    sort_enable        = 1'b0;
    sort_write         = 1'b0;
    pop                = 1'b0;
    sort_unsorted_data = in_data;
    case (state_q)
      LOAD: begin
        in_ready    = 1'b1;
        sort_write  = 1'b1;
        sort_enable = in_valid;
      end
      DRAIN: begin
        pop         = !out_valid_q || out_ready;
        sort_enable = pop;
      end
      default: ;
    endcase
  end

  assign sort_clear = reset || (state_q == CLEAR);
  assign busy       = (state_q != LOAD) || (cnt_q != '0);
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;

endmodule

// File: tb/tb_sort_stream_sequencer.sv
// Directed bench for sort_stream_sequencer with a behavioural sorter.
module tb_sort_stream_sequencer;

  localparam int DW = 8;
  localparam int SZ = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;
  logic          sort_enable;
  logic          sort_write;
  logic [DW-1:0] sort_unsorted_data;
  logic [DW-1:0] sort_sorted_data;
  logic          sort_clear;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int ins_cnt  = 0;

  logic [DW-1:0] col_d[8];
  logic          col_l[8];
  int            col_n;

  always #5 clk = ~clk;

  sort_stream_sequencer #(
    .DATA_WIDTH   (DW),
    .SIZE         (SZ),
    .SETTLE_CYCLES(1)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_last          (out_last),
    .out_ready         (out_ready),
    .sort_enable       (sort_enable),
    .sort_write        (sort_write),
    .sort_unsorted_data(sort_unsorted_data),
    .sort_sorted_data  (sort_sorted_data),
    .sort_clear        (sort_clear),
    .busy              (busy)
  );

  // Behavioural sorter: ascending insertion list, head on sorted_data.
  logic [DW-1:0] mem[SZ];
  int            mcount = 0;

  assign sort_sorted_data = (mcount > 0) ? mem[0] : '0;

  always @(posedge clk) begin
    logic [DW-1:0] t[SZ];
    int n;
    int p;
    t = mem;
    n = mcount;
    if (sort_clear) begin
      n = 0;
    end else if (sort_enable && sort_write && n < SZ) begin
      p = n;
      while (p > 0 && t[p-1] > sort_unsorted_data) begin
        t[p] = t[p-1];
        p--;
      end
      t[p] = sort_unsorted_data;
      n++;
      ins_cnt++;
    end else if (sort_enable && !sort_write && n > 0) begin
      for (int i = 0; i < SZ - 1; i++) t[i] = t[i+1];
      n--;
    end
    mem    <= t;
    mcount <= n;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int guard;
    guard = 0;
    #1;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    if (guard >= 20) chk("in_ready_timeout", 32'(in_ready), 1);
  endtask

  task automatic feed3(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
    logic [DW-1:0] v[3];
    v[0] = a; v[1] = b; v[2] = c;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b0;
      wait_ready();
      in_valid = 1'b1;
      in_data  = v[i];
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int n);
    int guard;
    guard = 0;
    col_n = 0;
    while (col_n < n && guard < 40) begin
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        col_d[col_n] = out_data;
        col_l[col_n] = out_last;
        col_n++;
      end
      step();
      guard++;
    end
    if (col_n < n) chk("collect_timeout", 32'(col_n), 32'(n));
  endtask

  task automatic chk_frame(input string tag, input logic [DW-1:0] e0,
                           input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    chk({tag, "_d0"}, 32'(col_d[0]), 32'(e0));
    chk({tag, "_d1"}, 32'(col_d[1]), 32'(e1));
    chk({tag, "_d2"}, 32'(col_d[2]), 32'(e2));
    chk({tag, "_lastmask"}, {29'd0, col_l[2], col_l[1], col_l[0]}, 32'b100);
  endtask

  initial begin
    logic [DW-1:0] t1d[3];
    logic [DW-1:0] t1e[3];
    logic          t3v[5];
    logic [DW-1:0] t3d[5];
    int            ins_base;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    chk("reset_sort_clear", 32'(sort_clear), 1);
    step();
    step();
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_data", 32'(out_data), 0);
    chk("reset_busy", 32'(busy), 0);
    reset = 1'b0;
    #1;
    chk("idle_sort_clear", 32'(sort_clear), 0);
    chk("idle_in_ready", 32'(in_ready), 1);

    // 1: 5,2,9 back to back with cycle-level checks.
    t1d[0] = 8'd5; t1d[1] = 8'd2; t1d[2] = 8'd9;
    t1e[0] = 8'd2; t1e[1] = 8'd5; t1e[2] = 8'd9;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = t1d[i];
      #1;
      chk("t1_load_in_ready", 32'(in_ready), 1);
      chk("t1_load_enable", 32'(sort_enable), 1);
      chk("t1_load_write", 32'(sort_write), 1);
      chk("t1_load_udata", 32'(sort_unsorted_data), 32'(t1d[i]));
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("t1_settle_in_ready", 32'(in_ready), 0);
    chk("t1_settle_enable", 32'(sort_enable), 0);
    chk("t1_settle_write", 32'(sort_write), 0);
    chk("t1_settle_busy", 32'(busy), 1);
    step();
    chk("t1_drain_enable", 32'(sort_enable), 1);
    chk("t1_drain_write", 32'(sort_write), 0);
    chk("t1_drain_out_valid", 32'(out_valid), 0);
    step();
    for (int k = 0; k < 3; k++) begin
      chk("t1_out_valid", 32'(out_valid), 1);
      chk("t1_out_data", 32'(out_data), 32'(t1e[k]));
      chk("t1_out_last", 32'(out_last), (k == 2) ? 1 : 0);
      chk("t1_sort_clear", 32'(sort_clear), (k == 2) ? 1 : 0);
      if (k == 2) begin
        chk("t1_clear_enable", 32'(sort_enable), 0);
        chk("t1_clear_in_ready", 32'(in_ready), 0);
        chk("t1_clear_write", 32'(sort_write), 0);
      end
      step();
    end
    chk("t1_after_clear", 32'(sort_clear), 0);
    chk("t1_after_valid", 32'(out_valid), 0);
    chk("t1_after_busy", 32'(busy), 0);

    // 2: stall for 4 cycles after the first output.
    feed3(8'd5, 8'd2, 8'd9);
    collect(0);
    begin
      int guard;
      guard = 0;
      #1;
      while (!out_valid && guard < 10) begin
        step();
        guard++;
      end
      chk("t2_first_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_stall_valid", 32'(out_valid), 1);
      chk("t2_stall_data", 32'(out_data), 2);
      chk("t2_stall_enable", 32'(sort_enable), 0);
      step();
    end
    collect(3);
    chk_frame("t2", 8'd2, 8'd5, 8'd9);

    // 3: gappy input, only valid beats insert.
    t3v[0] = 1; t3v[1] = 0; t3v[2] = 1; t3v[3] = 0; t3v[4] = 1;
    t3d[0] = 8'd4; t3d[1] = 8'd200; t3d[2] = 8'd1; t3d[3] = 8'd150; t3d[4] = 8'd3;
    in_valid = 1'b0;
    wait_ready();
    ins_base = ins_cnt;
    for (int i = 0; i < 5; i++) begin
      in_valid = t3v[i];
      in_data  = t3d[i];
      step();
    end
    in_valid = 1'b0;
    chk("t3_inserts", 32'(ins_cnt - ins_base), 3);
    collect(3);
    chk_frame("t3", 8'd1, 8'd3, 8'd4);

    // 4: duplicates.
    feed3(8'd7, 8'd7, 8'd0);
    collect(3);
    chk_frame("t4", 8'd0, 8'd7, 8'd7);

    // 5: reset right after the first output of a frame.
    feed3(8'd5, 8'd2, 8'd9);
    collect(1);
    chk("t5_first", 32'(col_d[0]), 2);
    reset = 1'b1;
    #1;
    chk("t5_reset_clear", 32'(sort_clear), 1);
    step();
    reset = 1'b0;
    #1;
    chk("t5_post_valid", 32'(out_valid), 0);
    chk("t5_post_busy", 32'(busy), 0);
    feed3(8'd1, 8'd3, 8'd2);
    collect(3);
    chk_frame("t5", 8'd1, 8'd2, 8'd3);

    // 6: last element held while the next frame loads.
    feed3(8'd5, 8'd2, 8'd9);
    collect(2);
    out_ready = 1'b0;
    #1;
    chk("t6_pending_valid", 32'(out_valid), 1);
    chk("t6_pending_data", 32'(out_data), 9);
    chk("t6_pending_last", 32'(out_last), 1);
    wait_ready();
    t1d[0] = 8'd8; t1d[1] = 8'd4; t1d[2] = 8'd6;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = t1d[i];
      #1;
      chk("t6_load_in_ready", 32'(in_ready), 1);
      chk("t6_load_held_valid", 32'(out_valid), 1);
      chk("t6_load_held_data", 32'(out_data), 9);
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t6_stall_enable", 32'(sort_enable), 0);
      chk("t6_stall_data", 32'(out_data), 9);
      step();
    end
    collect(4);
    chk("t6_d0", 32'(col_d[0]), 9);
    chk("t6_d1", 32'(col_d[1]), 4);
    chk("t6_d2", 32'(col_d[2]), 6);
    chk("t6_d3", 32'(col_d[3]), 8);
    chk("t6_lastmask", {28'd0, col_l[3], col_l[2], col_l[1], col_l[0]}, 32'b1001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
